// File: rtl/run_controller_if.sv
// Host-facing handshake channels of the run controller: the load-beat
// stream into data memory and the dump-word stream back out.
interface run_controller_if;
    logic       host_valid;
    logic       host_ready;
    logic [7:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_last;
    logic       dump_valid;
    logic       dump_ready;
    logic [7:0] dump_addr;
    logic [7:0] dump_data;

    // host / loader side
    modport master (
        output host_valid, host_addr, host_wdata, host_last, dump_ready,
        input  host_ready, dump_valid, dump_addr, dump_data
    );

    // controller side
    modport slave (
        input  host_valid, host_addr, host_wdata, host_last, dump_ready,
        output host_ready, dump_valid, dump_addr, dump_data
    );
endinterface

// File: rtl/run_controller.sv
// Program-run sequencer: holds the core in start, loads data memory from the
// host, runs the core until halt or timeout, then dumps a memory window.
// Owns the single data-memory port and muxes it between host and core.
module run_controller #(
    parameter int unsigned             CYC_W   = 16,
    parameter logic [CYC_W-1:0]        TIMEOUT = 16'hFFFF
) (
    input  logic                CLK,
    input  logic                reset_n,
    input  logic                go,
    input  logic [7:0]          dump_base,
    input  logic [7:0]          dump_len,
    run_controller_if.slave     bus,
    output logic                core_start,
    input  logic                core_halt,
    input  logic                core_mem_we,
    input  logic [7:0]          core_mem_addr,
    input  logic [7:0]          core_mem_wdata,
    output logic [7:0]          core_mem_rdata,
    output logic                mem_we,
    output logic [7:0]          mem_addr,
    output logic [7:0]          mem_wdata,
    input  logic [7:0]          mem_rdata,
    output logic [CYC_W-1:0]    run_cycles,
    output logic                timed_out,
    output logic                done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DUMP_RD,
        DUMP_OUT,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         base_q, len_q;
    logic [7:0]         ptr_q, remaining_q;
    logic [7:0]         dump_addr_q, dump_data_q;
    logic [CYC_W-1:0]   run_cycles_q;
    logic               timed_out_q;
    logic               start_seq;
    logic               run_exit;
    logic               dump_hs;

    // state register
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state decode; halt takes priority over timeout on the RUN exit
    always_comb begin
        state_d   = state_q;
        start_seq = 1'b0;
        run_exit  = 1'b0;
        dump_hs   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (go) begin
                    start_seq = 1'b1;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                if (bus.host_valid && bus.host_last) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (core_halt || (run_cycles_q == TIMEOUT)) begin
                    run_exit = 1'b1;
                    state_d  = (len_q == '0) ? DONE : DUMP_RD;
                end
            end
            DUMP_RD: begin
                state_d = DUMP_OUT;
            end
            DUMP_OUT: begin
                if (bus.dump_ready) begin
                    dump_hs = 1'b1;
                    state_d = (remaining_q == 8'd1) ? DONE : DUMP_RD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // sequence datapath: latched window, run counter, dump pointer and word
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            base_q       <= '0;
            len_q        <= '0;
            ptr_q        <= '0;
            remaining_q  <= '0;
            dump_addr_q  <= '0;
            dump_data_q  <= '0;
            run_cycles_q <= '0;
            timed_out_q  <= 1'b0;
        end else begin
            if (start_seq) begin
                base_q       <= dump_base;
                len_q        <= dump_len;
                run_cycles_q <= '0;
                timed_out_q  <= 1'b0;
            end
            if (state_q == RUN) begin
                if (run_exit) begin
                    timed_out_q <= !core_halt;
                    ptr_q       <= base_q;
                    remaining_q <= len_q;
                end else if (run_cycles_q != '1) begin
                    run_cycles_q <= run_cycles_q + 1'b1;
                end
            end
            if (state_q == DUMP_RD) begin
                dump_addr_q <= ptr_q;
                dump_data_q <= mem_rdata;
            end
            if (dump_hs) begin
                ptr_q       <= ptr_q + 8'd1;
                remaining_q <= remaining_q - 8'd1;
            end
        end
    end

    // memory port mux and state-decoded outputs
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = ptr_q;
        mem_wdata = '0;
        case (state_q)
            LOAD: begin
                mem_we    = bus.host_valid;
                mem_addr  = bus.host_addr;
                mem_wdata = bus.host_wdata;
            end
            RUN: begin
                mem_we    = core_mem_we;
                mem_addr  = core_mem_addr;
                mem_wdata = core_mem_wdata;
            end
            default: begin
            end
        endcase
    end

    assign core_start     = (state_q != RUN);
    assign bus.host_ready = (state_q == LOAD);
    assign bus.dump_valid = (state_q == DUMP_OUT);
    assign bus.dump_addr  = dump_addr_q;
    assign bus.dump_data  = dump_data_q;
    assign done           = (state_q == DONE);
    assign run_cycles     = run_cycles_q;
    assign timed_out      = timed_out_q;
    assign core_mem_rdata = mem_rdata;

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: emulates the data memory and the core's
// load/store path, and checks outputs one cycle at a time.
module tb_run_controller;

    logic        CLK = 1'b0;
    logic        reset_n;
    logic        go;
    logic [7:0]  dump_base, dump_len;
    logic        core_start, core_halt;
    logic        core_mem_we;
    logic [7:0]  core_mem_addr, core_mem_wdata, core_mem_rdata;
    logic        mem_we;
    logic [7:0]  mem_addr, mem_wdata, mem_rdata;
    logic [15:0] run_cycles;
    logic        timed_out, done;
    logic        mem_init;
    logic [7:0]  mem [256];

    int compared   = 0;
    int mismatched = 0;

    run_controller_if bus ();

    run_controller #(.CYC_W(16), .TIMEOUT(16'd100)) dut (
        .CLK            (CLK),
        .reset_n        (reset_n),
        .go             (go),
        .dump_base      (dump_base),
        .dump_len       (dump_len),
        .bus            (bus),
        .core_start     (core_start),
        .core_halt      (core_halt),
        .core_mem_we    (core_mem_we),
        .core_mem_addr  (core_mem_addr),
        .core_mem_wdata (core_mem_wdata),
        .core_mem_rdata (core_mem_rdata),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .run_cycles     (run_cycles),
        .timed_out      (timed_out),
        .done           (done)
    );

    always #5 CLK = ~CLK;

    // data memory model: combinational read, write on rising edge
    always @(posedge CLK) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'hEE;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [7:0] a, input logic [7:0] d);
        chk({tag, "_valid"}, {15'd0, bus.dump_valid}, 16'd1);
        chk({tag, "_addr"},  {8'd0, bus.dump_addr},   {8'd0, a});
        chk({tag, "_data"},  {8'd0, bus.dump_data},   {8'd0, d});
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_start"}, {15'd0, core_start},     16'd1);
        chk({tag, "_hrdy"},  {15'd0, bus.host_ready}, 16'd0);
        chk({tag, "_dval"},  {15'd0, bus.dump_valid}, 16'd0);
        chk({tag, "_done"},  {15'd0, done},           16'd0);
        chk({tag, "_tout"},  {15'd0, timed_out},      16'd0);
        chk({tag, "_rc"},    run_cycles,              16'd0);
        chk({tag, "_daddr"}, {8'd0, bus.dump_addr},   16'd0);
        chk({tag, "_ddata"}, {8'd0, bus.dump_data},   16'd0);
        chk({tag, "_we"},    {15'd0, mem_we},         16'd0);
    endtask

    initial begin
        reset_n = 1'b0; go = 1'b0; dump_base = '0; dump_len = '0;
        core_halt = 1'b0; core_mem_we = 1'b0; core_mem_addr = '0; core_mem_wdata = '0;
        bus.host_valid = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
        bus.host_last = 1'b0; bus.dump_ready = 1'b0;
        mem_init = 1'b1;
        tick(); tick();
        mem_init = 1'b0;
        chk_reset("rst0");

        // ---- run 1: load 16..18, core halts after 40 cycles, dump 3 words
        reset_n = 1'b1;
        tick();
        go = 1'b1; dump_base = 8'd16; dump_len = 8'd3;
        tick();
        go = 1'b0;
        chk("go_hrdy", {15'd0, bus.host_ready}, 16'd1);
        chk("go_start", {15'd0, core_start}, 16'd1);
        core_mem_we = 1'b1; core_mem_addr = 8'd5; core_mem_wdata = 8'hAA;
        tick();
        chk("load_idle_mem5", {8'd0, mem[5]}, 16'h00EE);
        bus.host_valid = 1'b1; bus.host_addr = 8'd16; bus.host_wdata = 8'h00;
        tick();
        chk("load_m16", {8'd0, mem[16]}, 16'h0000);
        bus.host_addr = 8'd17; bus.host_wdata = 8'h10;
        tick();
        chk("load_m17", {8'd0, mem[17]}, 16'h0010);
        bus.host_addr = 8'd18; bus.host_wdata = 8'h00; bus.host_last = 1'b1;
        tick();
        chk("load_m18", {8'd0, mem[18]}, 16'h0000);
        chk("load_m5_dropped", {8'd0, mem[5]}, 16'h00EE);
        chk("run_start_low", {15'd0, core_start}, 16'd0);
        chk("run_hrdy_low", {15'd0, bus.host_ready}, 16'd0);
        bus.host_valid = 1'b0; bus.host_last = 1'b0;
        tick();
        chk("run_m5_written", {8'd0, mem[5]}, 16'h00AA);
        core_mem_addr = 8'd18; core_mem_wdata = 8'h42;
        go = 1'b1;
        tick();
        go = 1'b0;
        core_mem_we = 1'b0;
        chk("run_go_ignored", {15'd0, core_start}, 16'd0);
        repeat (38) tick();
        chk("run_rc40_pre", run_cycles, 16'd40);
        core_halt = 1'b1;
        tick();
        core_halt = 1'b0;
        chk("halt_rc", run_cycles, 16'd40);
        chk("halt_tout", {15'd0, timed_out}, 16'd0);
        chk("halt_start", {15'd0, core_start}, 16'd1);
        chk("halt_dval0", {15'd0, bus.dump_valid}, 16'd0);
        tick();
        chk_word("d1w0", 8'd16, 8'h00);
        bus.dump_ready = 1'b1;
        tick();
        chk("d1_gap", {15'd0, bus.dump_valid}, 16'd0);
        tick();
        chk_word("d1w1", 8'd17, 8'h10);
        tick(); tick();
        chk_word("d1w2", 8'd18, 8'h42);
        tick();
        bus.dump_ready = 1'b0;
        chk("d1_done", {15'd0, done}, 16'd1);
        chk("d1_done_start", {15'd0, core_start}, 16'd1);
        core_mem_we = 1'b1; core_mem_addr = 8'd5; core_mem_wdata = 8'h77;
        tick();
        core_mem_we = 1'b0;
        chk("done_m5_dropped", {8'd0, mem[5]}, 16'h00AA);
        chk("done_we", {15'd0, mem_we}, 16'd0);

        // ---- run 2: restart from DONE, lone last beat, timeout, wrap, stall
        go = 1'b1; dump_base = 8'd254; dump_len = 8'd4;
        tick();
        go = 1'b0;
        chk("r2_rc_clr", run_cycles, 16'd0);
        chk("r2_hrdy", {15'd0, bus.host_ready}, 16'd1);
        bus.host_valid = 1'b1; bus.host_last = 1'b1;
        bus.host_addr = 8'd254; bus.host_wdata = 8'h5A;
        tick();
        bus.host_valid = 1'b0; bus.host_last = 1'b0;
        chk("r2_lone_beat", {8'd0, mem[254]}, 16'h005A);
        chk("r2_start_low", {15'd0, core_start}, 16'd0);
        core_mem_we = 1'b1; core_mem_addr = 8'd255; core_mem_wdata = 8'h11;
        tick();
        core_mem_addr = 8'd0; core_mem_wdata = 8'h22;
        tick();
        core_mem_addr = 8'd1; core_mem_wdata = 8'h33;
        tick();
        core_mem_we = 1'b0;
        repeat (97) tick();
        chk("to_rc100_pre", run_cycles, 16'd100);
        chk("to_still_run", {15'd0, core_start}, 16'd0);
        chk("to_tout_pre", {15'd0, timed_out}, 16'd0);
        tick();
        chk("to_tout", {15'd0, timed_out}, 16'd1);
        chk("to_rc", run_cycles, 16'd100);
        chk("to_start", {15'd0, core_start}, 16'd1);
        tick();
        chk_word("d2w0", 8'd254, 8'h5A);
        bus.dump_ready = 1'b1;
        tick();
        bus.dump_ready = 1'b0;
        tick();
        chk_word("d2w1", 8'd255, 8'h11);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_word("d2_stall", 8'd255, 8'h11);
        end
        bus.dump_ready = 1'b1;
        tick();
        chk("d2_gap", {15'd0, bus.dump_valid}, 16'd0);
        tick();
        chk_word("d2w2", 8'd0, 8'h22);
        tick(); tick();
        chk_word("d2w3", 8'd1, 8'h33);
        tick();
        bus.dump_ready = 1'b0;
        chk("d2_done", {15'd0, done}, 16'd1);
        chk("d2_tout_kept", {15'd0, timed_out}, 16'd1);

        // ---- run 3: reset during DUMP_OUT, then a len=0 run
        go = 1'b1; dump_base = 8'd16; dump_len = 8'd2;
        tick();
        go = 1'b0;
        bus.host_valid = 1'b1; bus.host_last = 1'b1;
        bus.host_addr = 8'd30; bus.host_wdata = 8'h99;
        tick();
        bus.host_valid = 1'b0; bus.host_last = 1'b0;
        repeat (7) tick();
        core_halt = 1'b1;
        tick();
        core_halt = 1'b0;
        tick();
        chk("r3_rc7", run_cycles, 16'd7);
        chk_word("r3w0", 8'd16, 8'h00);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk_reset("rst_mid");
        go = 1'b1; dump_base = 8'd20; dump_len = 8'd0;
        tick();
        go = 1'b0;
        chk("r4_hrdy", {15'd0, bus.host_ready}, 16'd1);
        bus.host_valid = 1'b1; bus.host_last = 1'b1;
        bus.host_addr = 8'd30; bus.host_wdata = 8'h98;
        tick();
        bus.host_valid = 1'b0; bus.host_last = 1'b0;
        chk("r4_m30", {8'd0, mem[30]}, 16'h0098);
        chk("r4_rc0", run_cycles, 16'd0);
        repeat (3) tick();
        core_halt = 1'b1;
        tick();
        core_halt = 1'b0;
        chk("r4_done", {15'd0, done}, 16'd1);
        chk("r4_rc3", run_cycles, 16'd3);
        chk("r4_dval", {15'd0, bus.dump_valid}, 16'd0);
        chk("r4_tout", {15'd0, timed_out}, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
